// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Alignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
package dmem_responder_pkg;

    localparam int unsigned REGISTER_WIDTH = 32;
    localparam int unsigned BYTE_WIDTH     = 8;
    localparam int unsigned BYTE_LANES     = REGISTER_WIDTH / BYTE_WIDTH;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_t;

    // Widen a per-lane enable into a per-bit mask.
    function automatic logic [REGISTER_WIDTH-1:0] expand_mask(input logic [BYTE_LANES-1:0] m);
        logic [REGISTER_WIDTH-1:0] res;
        res = '0;
        for (int l = 0; l < int'(BYTE_LANES); l++) begin
            res[l*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{m[l]}};
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's load/store port and the responder.
interface dmem_responder_if;

    logic                                        req_valid;
    logic                                        req_ready;
    logic [dmem_responder_pkg::REGISTER_WIDTH-1:0] req_address;
    logic                                        req_write_en;
    logic [dmem_responder_pkg::REGISTER_WIDTH-1:0] req_write_data;
    logic [dmem_responder_pkg::BYTE_LANES-1:0]     req_byte_enable;
    logic                                        resp_valid;
    logic                                        resp_ready;
    logic [dmem_responder_pkg::REGISTER_WIDTH-1:0] resp_read_data;
    logic                                        resp_error;

    modport master (
        output req_valid, req_address, req_write_en, req_write_data, req_byte_enable,
        output resp_ready,
        input  req_ready, resp_valid, resp_read_data, resp_error
    );

    modport slave (
        input  req_valid, req_address, req_write_en, req_write_data, req_byte_enable,
        input  resp_ready,
        output req_ready, resp_valid, resp_read_data, resp_error
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering between lane-0-relative requests and word-organised RAM.
// Misalign flag is always computed; the top decides whether it counts as an error.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [BYTE_LANES-1:0]     be_i,
    input  logic [1:0]                off_i,
    input  logic [REGISTER_WIDTH-1:0] wdata_i,
    input  logic [REGISTER_WIDTH-1:0] rdata_raw_i,
    output logic [BYTE_LANES-1:0]     lane_mask_o,
    output logic [REGISTER_WIDTH-1:0] wdata_o,
    output logic [REGISTER_WIDTH-1:0] rdata_o,
    output logic                      misalign_o
);

    logic [2*BYTE_LANES-1:0] mask_wide;
    logic [4:0]              bit_shift;

    assign bit_shift = {off_i, 3'b000};

    // Lanes pushed beyond lane 3 fall off the top and are dropped.
    assign mask_wide   = {{BYTE_LANES{1'b0}}, be_i} << off_i;
    assign lane_mask_o = mask_wide[BYTE_LANES-1:0];
    assign wdata_o     = wdata_i << bit_shift;
    assign rdata_o     = (rdata_raw_i >> bit_shift) & expand_mask(be_i);

    always_comb begin
        misalign_o = 1'b1;
        case (be_i)
            4'b0001: misalign_o = 1'b0;
            4'b0011: misalign_o = off_i[0];
            4'b1111: misalign_o = (off_i != 2'b00);
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_STATES cycles, then responds.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned or unsupported byte enables.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output logic             busy_o
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [REGISTER_WIDTH-1:0] addr_q, wdata_q;
    logic                      we_q;
    logic [BYTE_LANES-1:0]     be_q;
    logic [REGISTER_WIDTH-1:0] rdata_q;
    logic                      err_q;

    logic                      in_idle, accept, commit;
    logic [REGISTER_WIDTH-1:0] cur_addr, cur_wdata;
    logic                      cur_we;
    logic [BYTE_LANES-1:0]     cur_be;
    logic [IdxW-1:0]           idx;
    logic [REGISTER_WIDTH-1:0] upper_bits;
    logic                      out_of_range, access_err;
    logic [REGISTER_WIDTH-1:0] raw_word;
    logic [BYTE_LANES-1:0]     lane_mask;
    logic [REGISTER_WIDTH-1:0] wdata_sh, rdata_al;
    logic                      misalign;

    logic [REGISTER_WIDTH-1:0] mem [DEPTH_WORDS];

    assign in_idle       = (state_q == DMEM_IDLE);
    assign bus.req_ready = in_idle && rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign busy_o        = !in_idle;

    // With zero wait states the commit edge is the accept edge, so use the live request.
    assign cur_addr  = in_idle ? bus.req_address     : addr_q;
    assign cur_wdata = in_idle ? bus.req_write_data  : wdata_q;
    assign cur_we    = in_idle ? bus.req_write_en    : we_q;
    assign cur_be    = in_idle ? bus.req_byte_enable : be_q;

    assign idx          = cur_addr[2 +: IdxW];
    assign upper_bits   = cur_addr >> (IdxW + 2);
    assign out_of_range = (upper_bits != '0) || (32'(idx) >= DEPTH_WORDS);
    assign raw_word     = out_of_range ? '0 : mem[idx];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign access_err = out_of_range || misalign;
`else
    assign access_err = out_of_range;
`endif

    dmem_lane_align u_lane_align (
        .be_i        (cur_be),
        .off_i       (cur_addr[1:0]),
        .wdata_i     (cur_wdata),
        .rdata_raw_i (raw_word),
        .lane_mask_o (lane_mask),
        .wdata_o     (wdata_sh),
        .rdata_o     (rdata_al),
        .misalign_o  (misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            DMEM_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = DMEM_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = WaitInit;
                    end
                end
            end
            DMEM_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DMEM_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DMEM_RESP: begin
                if (bus.resp_ready) begin
                    state_d = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.req_address;
                wdata_q <= bus.req_write_data;
                we_q    <= bus.req_write_en;
                be_q    <= bus.req_byte_enable;
            end
            if (commit) begin
                rdata_q <= (cur_we || access_err) ? '0 : rdata_al;
                err_q   <= access_err;
            end
        end
    end

    // RAM has no reset; commit is impossible while rst is low since state_q is held in IDLE.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !access_err) begin
            for (int l = 0; l < int'(BYTE_LANES); l++) begin
                if (lane_mask[l]) begin
                    mem[idx][l*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_sh[l*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign bus.resp_valid     = (state_q == DMEM_RESP);
    assign bus.resp_read_data = rdata_q;
    assign bus.resp_error     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_STATES=2 and DEPTH_WORDS=1024.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned Depth = 1024;
    localparam int unsigned Ws    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] rd;
    logic        er;
    logic        seen;

    dmem_responder_if bus_if ();

    dmem_responder #(
        .DEPTH_WORDS (Depth),
        .WAIT_STATES (Ws)
    ) dut (
        .clk    (clk),
        .rst    (rst_n),
        .bus    (bus_if),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction with resp_ready already high before the response appears.
    task automatic xact(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        bus_if.req_address     = a;
        bus_if.req_write_en    = we;
        bus_if.req_write_data  = wd;
        bus_if.req_byte_enable = be;
        bus_if.req_valid       = 1'b1;
        bus_if.resp_ready      = 1'b1;
        n = 0;
        while (bus_if.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_at_accept", 32'(bus_if.req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble request fields: only the accept-edge values may matter.
        bus_if.req_valid       = 1'b0;
        bus_if.req_address     = 32'hFFFF_FFFC;
        bus_if.req_write_data  = 32'h5A5A_5A5A;
        bus_if.req_write_en    = ~we;
        bus_if.req_byte_enable = 4'hF;
        chk("busy_after_accept", 32'(busy), 32'd1);
        n = 1;
        while (bus_if.resp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(Ws + 1));
        rdata = bus_if.resp_read_data;
        err   = bus_if.resp_error;
        @(posedge clk);
        #1;
        chk("resp_valid_after_handshake", 32'(bus_if.resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.req_valid       = 1'b0;
        bus_if.req_address     = '0;
        bus_if.req_write_en    = 1'b0;
        bus_if.req_write_data  = '0;
        bus_if.req_byte_enable = '0;
        bus_if.resp_ready      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", bus_if.resp_read_data, 32'd0);
        chk("rst_err", 32'(bus_if.resp_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req_ready_after_release", 32'(bus_if.req_ready), 32'd1);

        // Known background contents
        xact(32'h0000_0000, 1'b1, 32'h1234_5678, 4'hF, rd, er);
        xact(32'h0000_0020, 1'b1, 32'hA5A5_A5A5, 4'hF, rd, er);
        xact(32'h0000_0040, 1'b1, 32'h0000_0077, 4'hF, rd, er);

        // Word store / load
        xact(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata_zero", rd, 32'd0);
        xact(32'h0000_0010, 1'b0, 32'd0, 4'hF, rd, er);
        chk("lw_10", rd, 32'hDEAD_BEEF);
        chk("lw_10_err", 32'(er), 32'd0);

        // Byte store and sub-word loads
        xact(32'h0000_0013, 1'b1, 32'h0000_00AB, 4'b0001, rd, er);
        chk("sb_err", 32'(er), 32'd0);
        xact(32'h0000_0010, 1'b0, 32'd0, 4'hF, rd, er);
        chk("lw_after_sb", rd, 32'hABAD_BEEF);
        xact(32'h0000_0013, 1'b0, 32'd0, 4'b0001, rd, er);
        chk("lbu_13", rd, 32'h0000_00AB);
        xact(32'h0000_0012, 1'b0, 32'd0, 4'b0011, rd, er);
        chk("lh_12", rd, 32'h0000_ABAD);

        // Backpressure: response held, concurrent request ignored
        @(negedge clk);
        bus_if.req_address     = 32'h0000_0010;
        bus_if.req_write_en    = 1'b0;
        bus_if.req_byte_enable = 4'hF;
        bus_if.req_valid       = 1'b1;
        bus_if.resp_ready      = 1'b0;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        repeat (Ws) @(posedge clk);
        #1;
        chk("bp_resp_valid", 32'(bus_if.resp_valid), 32'd1);
        chk("bp_rdata", bus_if.resp_read_data, 32'hABAD_BEEF);
        @(negedge clk);
        bus_if.req_address     = 32'h0000_0020;
        bus_if.req_write_en    = 1'b1;
        bus_if.req_write_data  = 32'hFFFF_FFFF;
        bus_if.req_byte_enable = 4'hF;
        bus_if.req_valid       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus_if.resp_valid), 32'd1);
            chk("hold_data", bus_if.resp_read_data, 32'hABAD_BEEF);
            chk("hold_err", 32'(bus_if.resp_error), 32'd0);
            chk("hold_req_ready", 32'(bus_if.req_ready), 32'd0);
        end
        @(negedge clk);
        bus_if.req_valid  = 1'b0;
        bus_if.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", 32'(bus_if.resp_valid), 32'd0);
        xact(32'h0000_0020, 1'b0, 32'd0, 4'hF, rd, er);
        chk("ignored_store", rd, 32'hA5A5_A5A5);

        // Out of range
        xact(32'(4 * Depth), 1'b1, 32'h1111_1111, 4'hF, rd, er);
        chk("oob_sw_err", 32'(er), 32'd1);
        xact(32'(4 * Depth), 1'b0, 32'd0, 4'hF, rd, er);
        chk("oob_lw_err", 32'(er), 32'd1);
        chk("oob_lw_rdata", rd, 32'd0);
        xact(32'h8000_0000, 1'b0, 32'd0, 4'hF, rd, er);
        chk("oob_high_err", 32'(er), 32'd1);
        xact(32'h0000_0000, 1'b0, 32'd0, 4'hF, rd, er);
        chk("lw_0_unchanged", rd, 32'h1234_5678);

        // Halfword at odd offset
        xact(32'h0000_0011, 1'b1, 32'h0000_CAFE, 4'b0011, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("sh_11_err", 32'(er), 32'd1);
        xact(32'h0000_0010, 1'b0, 32'd0, 4'hF, rd, er);
        chk("lw_after_sh", rd, 32'hABAD_BEEF);
`else
        chk("sh_11_err", 32'(er), 32'd0);
        xact(32'h0000_0010, 1'b0, 32'd0, 4'hF, rd, er);
        chk("lw_after_sh", rd, 32'hABCA_FEEF);
`endif

        // Reset during WAIT drops the transaction
        @(negedge clk);
        bus_if.req_address     = 32'h0000_0040;
        bus_if.req_write_en    = 1'b1;
        bus_if.req_write_data  = 32'h0000_0005;
        bus_if.req_byte_enable = 4'hF;
        bus_if.req_valid       = 1'b1;
        bus_if.resp_ready      = 1'b1;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(bus_if.req_ready), 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus_if.resp_valid === 1'b1) seen = 1'b1;
        end
        chk("no_resp_after_rst", 32'(seen), 32'd0);
        xact(32'h0000_0040, 1'b0, 32'd0, 4'hF, rd, er);
        chk("lw_40_unchanged", rd, 32'h0000_0077);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
